// File: rtl/i2c_codec_responder_pkg.sv
// Shared constants for the WM8731-style I2C control responder: device address,
// FSM encoding, register indices and the power-on register image.
package i2c_codec_responder_pkg;

    localparam logic [6:0] DEV_ADDR   = 7'b0011010;

    localparam logic [6:0] RegLvol    = 7'h02;
    localparam logic [6:0] RegRvol    = 7'h03;
    localparam logic [6:0] RegActive  = 7'h09;
    localparam logic [6:0] RegReset   = 7'h0F;
    localparam logic [6:0] RegLastImg = 7'h09;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAckAddr,
        StSub,
        StAckSub,
        StData,
        StAckData,
        StIgnore
    } state_e;

    function automatic logic [8:0] reg_default(input logic [3:0] idx);
        logic [8:0] val;
        case (idx)
            4'h0, 4'h1: val = 9'h097;
            4'h2, 4'h3: val = 9'h079;
            4'h4:       val = 9'h00A;
            4'h5:       val = 9'h008;
            4'h6:       val = 9'h09F;
            4'h7:       val = 9'h00A;
            default:    val = 9'h000;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/i2c_codec_responder_if.sv
// Write-report and register-readback bundle between the responder (master side)
// and downstream audio logic (slave side).
interface i2c_codec_responder_if;

    logic       wr_valid;
    logic [6:0] wr_reg;
    logic [8:0] wr_data;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic [6:0] vol_left;
    logic [6:0] vol_right;
    logic       codec_active;
    logic       bad_reg;

    modport master (
        output wr_valid, wr_reg, wr_data, rd_data, vol_left, vol_right, codec_active, bad_reg,
        input  rd_addr
    );

    modport slave (
        input  wr_valid, wr_reg, wr_data, rd_data, vol_left, vol_right, codec_active, bad_reg,
        output rd_addr
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus registered START, STOP and SCL edge pulses.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic sda,
    output logic start,
    output logic stop,
    output logic scl_rise,
    output logic scl_fall
);

    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;
    logic start_q, stop_q, scl_rise_q, scl_fall_q;

    // Idle bus is high on both lines, so reset the pipeline high to avoid false edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
        end else begin
            scl_meta_q <= scl_raw;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda_raw;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
            scl_rise_q <= scl_sync_q & ~scl_prev_q;
            scl_fall_q <= ~scl_sync_q & scl_prev_q;
            start_q    <= scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
            stop_q     <= scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
        end
    end

    // sda_prev_q holds the level seen on the same cycle the edge pulse was formed.
    assign sda      = sda_prev_q;
    assign start    = start_q;
    assign stop     = stop_q;
    assign scl_rise = scl_rise_q;
    assign scl_fall = scl_fall_q;

endmodule

// File: rtl/i2c_codec_responder.sv
// Write-only I2C responder emulating the WM8731 control port, with a 16x9 register
// image, reset-register handling and decoded volume/active outputs.
module i2c_codec_responder
    import i2c_codec_responder_pkg::*;
(
    input  logic                         clk_i2c,
    input  logic                         reset_n,
    input  logic                         I2C_SCLK,
    inout  wire                          I2C_SDAT,
    i2c_codec_responder_if.master        ctrl
);

    logic sda_bit, start, stop, scl_rise, scl_fall;

    i2c_bus_sync u_sync (
        .clk      (clk_i2c),
        .rst_n    (reset_n),
        .scl_raw  (I2C_SCLK),
        .sda_raw  (I2C_SDAT),
        .sda      (sda_bit),
        .start    (start),
        .stop     (stop),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall)
    );

    state_e     state_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic [6:0] reg_idx_q;
    logic       data_hi_q;
    logic       sda_low_q;
    logic       wr_valid_q;
    logic [6:0] wr_reg_q;
    logic [8:0] wr_data_q;
    logic       bad_reg_q;
    logic [8:0] image_q [16];

    logic [7:0] byte_next;
    assign byte_next = {shift_q, sda_bit};

    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            reg_idx_q  <= 7'd0;
            data_hi_q  <= 1'b0;
            sda_low_q  <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_reg_q   <= 7'd0;
            wr_data_q  <= 9'd0;
            bad_reg_q  <= 1'b0;
            for (int i = 0; i < 16; i++) image_q[i] <= reg_default(4'(i));
        end else begin
            wr_valid_q <= 1'b0;
            if (stop) begin
                state_q   <= StIdle;
                bit_cnt_q <= 3'd0;
                sda_low_q <= 1'b0;
            end else if (start) begin
                state_q   <= StAddr;
                bit_cnt_q <= 3'd0;
                sda_low_q <= 1'b0;
            end else begin
                case (state_q)
                    StAddr, StSub, StData: begin
                        if (scl_rise) begin
                            shift_q   <= byte_next[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (state_q == StAddr) begin
                                    // Reads and foreign addresses are simply not acknowledged.
                                    state_q <= (byte_next == {DEV_ADDR, 1'b0}) ? StAckAddr
                                                                               : StIgnore;
                                end else if (state_q == StSub) begin
                                    reg_idx_q <= byte_next[7:1];
                                    data_hi_q <= byte_next[0];
                                    state_q   <= StAckSub;
                                end else begin
                                    wr_valid_q <= 1'b1;
                                    wr_reg_q   <= reg_idx_q;
                                    wr_data_q  <= {data_hi_q, byte_next};
                                    if (reg_idx_q <= RegLastImg) begin
                                        image_q[reg_idx_q[3:0]] <= {data_hi_q, byte_next};
                                    end else if (reg_idx_q == RegReset) begin
                                        for (int i = 0; i < 16; i++) begin
                                            image_q[i] <= reg_default(4'(i));
                                        end
                                    end else begin
                                        bad_reg_q <= 1'b1;
                                    end
                                    state_q <= StAckData;
                                end
                            end
                        end
                    end
                    StAckAddr, StAckSub, StAckData: begin
                        // First fall after bit 0 starts the ACK, the next one ends it.
                        if (scl_fall) begin
                            if (!sda_low_q) begin
                                sda_low_q <= 1'b1;
                            end else begin
                                sda_low_q <= 1'b0;
                                bit_cnt_q <= 3'd0;
                                case (state_q)
                                    StAckAddr: state_q <= StSub;
                                    StAckSub:  state_q <= StData;
                                    default:   state_q <= StIgnore;
                                endcase
                            end
                        end
                    end
                    StIdle, StIgnore: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign I2C_SDAT = sda_low_q ? 1'b0 : 1'bz;

    assign ctrl.wr_valid     = wr_valid_q;
    assign ctrl.wr_reg       = wr_reg_q;
    assign ctrl.wr_data      = wr_data_q;
    assign ctrl.bad_reg      = bad_reg_q;
    assign ctrl.rd_data      = image_q[ctrl.rd_addr];
    assign ctrl.vol_left     = image_q[RegLvol[3:0]][6:0];
    assign ctrl.vol_right    = image_q[RegRvol[3:0]][6:0];
    assign ctrl.codec_active = image_q[RegActive[3:0]][0];

endmodule
